ddma_engine: RTL and testbench

- DDMA responder; the counterpart of the TCD-side initiator on the DDMA command interface.
- Accepts a transfer command (word address, byte count) and reads the buffer from the local memory bus.
- Emits a NoC packet: header flit, size flit, then payload flits.
- Reports progress on status_out and latches completion and error interrupts on irq_out.

---
 rtl/ddma_pkg.sv | 38 +++
 rtl/ddma_flit_serializer.sv | 58 +++++
 rtl/ddma_engine.sv | 169 ++++++++++++++++
 tb/tb_ddma_engine.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddma_pkg.sv
// ddma_pkg: shared types and helpers for the DDMA responder.
//   state_e          FSM state encoding of ddma_engine
//   STATUS_* / IRQ_* bit positions inside status_out / irq_out
//   flits_per_word   number of flits carved out of one memory word
//   payload_flits    payload flit count P for a byte count
package ddma_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_SIZE,
    ST_REQ,
    ST_RD,
    ST_WAITD,
    ST_SEND,
    ST_YIELD,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_ERR     = 2;
  localparam int STATUS_OVERRUN = 3;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_ERR  = 1;

  function automatic int flits_per_word(input int mem_width, input int flit_width);
    return mem_width / flit_width;
  endfunction

  // Evaluated at full width so an oversized count can be detected by the caller.
  function automatic logic [63:0] payload_flits(input logic [63:0] nbytes, input int flit_width);
    return nbytes / 64'(flit_width / 8);
  endfunction

endpackage

// File: rtl/ddma_flit_serializer.sv
// ddma_flit_serializer: holds one memory word and hands it out as
// WORD_WIDTH/FLIT_WIDTH flits, least-significant slice first.
//   clock, reset  system clock, synchronous active-high reset
//   load          capture load_word and start presenting its first slice
//   load_word     memory word to serialise
//   ready         downstream ready; a slice retires when valid && ready
//   flit          current slice (0 when not valid)
//   valid         a slice is being presented
//   last          the slice being presented is the final one of the word
module ddma_flit_serializer
  import ddma_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int FLIT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_word,
  input  logic                  ready,
  output logic [FLIT_WIDTH-1:0] flit,
  output logic                  valid,
  output logic                  last
);

  localparam int FPW = flits_per_word(WORD_WIDTH, FLIT_WIDTH);
  localparam int CW  = (FPW > 1) ? $clog2(FPW) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FPW - 1);

  logic [WORD_WIDTH-1:0] word_buf;
  logic [CW-1:0]         slice_idx;
  logic                  valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      slice_idx <= '0;
    end else if (load) begin
      valid_q   <= 1'b1;
      slice_idx <= '0;
    end else if (valid_q && ready) begin
      if (slice_idx == LAST_IDX) valid_q <= 1'b0;
      else                       slice_idx <= slice_idx + CW'(1);
    end
  end

  // NOTE: the data register carries no reset; nothing downstream can observe
  // it while valid is low because the flit output is gated below.
  always_ff @(posedge clock) begin
    if (load)                                         word_buf <= load_word;
    else if (valid_q && ready && slice_idx != LAST_IDX) word_buf <= word_buf >> FLIT_WIDTH;
  end

  assign valid = valid_q;
  assign last  = valid_q && (slice_idx == LAST_IDX);
  assign flit  = valid_q ? word_buf[FLIT_WIDTH-1:0] : '0;

endmodule

// File: rtl/ddma_engine.sv
// ddma_engine: DDMA responder. Accepts a (word address, byte count) command,
// reads the buffer over the local memory bus and emits a NoC packet made of a
// header flit, a size flit and the payload flits.
//   clock, reset          system clock, synchronous active-high reset
//   addr_in, nbytes_in    command: start word address, length in bytes
//   cmd_in                start strobe, honoured only while idle
//   status_out            [0] busy [1] done [2] error [3] cmd_overrun
//   irq_out               [0] done_irq [1] err_irq, latched until next command
//   mem_req_o/mem_gnt_i   memory bus request / grant
//   mem_addr_o/mem_rd_o   word address and read strobe (data one cycle later)
//   mem_data_i            read data
//   flit_o/flit_valid_o   outgoing flit, held stable until flit_ready_i
module ddma_engine
  import ddma_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH   = 32,
  parameter int FLIT_WIDTH         = 16,
  parameter int INTERLEAVING_GRAIN = 4,
  parameter int ADDRESS            = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MEMORY_BUS_WIDTH-3:0] addr_in,
  input  logic [MEMORY_BUS_WIDTH-3:0] nbytes_in,
  input  logic                        cmd_in,
  output logic [4:0]                  status_out,
  output logic [4:0]                  irq_out,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic [MEMORY_BUS_WIDTH-3:0] mem_addr_o,
  output logic                        mem_rd_o,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_i,
  output logic [FLIT_WIDTH-1:0]       flit_o,
  output logic                        flit_valid_o,
  input  logic                        flit_ready_i
);

  localparam int AW             = MEMORY_BUS_WIDTH - 2;
  localparam int BYTES_PER_WORD = MEMORY_BUS_WIDTH / 8;
  localparam int GW             = (INTERLEAVING_GRAIN > 1) ? $clog2(INTERLEAVING_GRAIN) : 1;
  localparam logic [GW-1:0]         GRAIN_LAST = GW'(INTERLEAVING_GRAIN - 1);
  localparam logic [FLIT_WIDTH-1:0] HDR_FLIT   = FLIT_WIDTH'(ADDRESS);

  state_e                state;
  logic [AW-1:0]         addr_cnt;
  logic [AW-1:0]         words_left;
  logic [FLIT_WIDTH-1:0] p_flits;
  logic [GW-1:0]         grain_cnt;
  logic                  done_flag, err_flag, overrun_flag;
  logic                  done_irq, err_irq;

  logic [63:0]           p_full;
  logic                  cmd_bad;
  logic [FLIT_WIDTH-1:0] ser_flit;
  logic                  ser_valid, ser_last;

  // The command is judged from the live inputs at acceptance so that a bad
  // command goes straight to ERR and never shows a header flit.
  assign p_full  = payload_flits(64'(nbytes_in), FLIT_WIDTH);
  assign cmd_bad = (nbytes_in == '0) || (nbytes_in[1:0] != 2'b00) ||
                   (p_full >= (64'd1 << FLIT_WIDTH));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge value of every other one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_cnt     <= '0;
      words_left   <= '0;
      p_flits      <= '0;
      grain_cnt    <= '0;
      done_flag    <= 1'b0;
      err_flag     <= 1'b0;
      overrun_flag <= 1'b0;
      done_irq     <= 1'b0;
      err_irq      <= 1'b0;
    end else begin
      if (cmd_in && state != ST_IDLE) overrun_flag <= 1'b1;

      unique case (state)
        ST_IDLE: if (cmd_in) begin
          addr_cnt     <= addr_in;
          words_left   <= nbytes_in / AW'(BYTES_PER_WORD);
          p_flits      <= p_full[FLIT_WIDTH-1:0];
          grain_cnt    <= '0;
          done_flag    <= 1'b0;
          overrun_flag <= 1'b0;
          done_irq     <= 1'b0;
          err_flag     <= cmd_bad;
          err_irq      <= cmd_bad;
          state        <= cmd_bad ? ST_ERR : ST_HDR;
        end
        ST_HDR:   if (flit_ready_i) state <= ST_SIZE;
        ST_SIZE:  if (flit_ready_i) state <= ST_REQ;
        ST_REQ:   if (mem_gnt_i)    state <= ST_RD;
        ST_RD: begin
          addr_cnt <= addr_cnt + AW'(1);
          state    <= ST_WAITD;
        end
        ST_WAITD: state <= ST_SEND;
        ST_SEND: if (ser_last && flit_ready_i) begin
          words_left <= words_left - AW'(1);
          if (words_left == AW'(1)) begin
            done_flag <= 1'b1;
            done_irq  <= 1'b1;
            state     <= ST_DONE;
          end else if (grain_cnt == GRAIN_LAST) begin
            state <= ST_YIELD;
          end else begin
            grain_cnt <= grain_cnt + GW'(1);
            // A grant lost mid-grain must be re-arbitrated before the next read.
            state     <= mem_gnt_i ? ST_RD : ST_REQ;
          end
        end
        ST_YIELD: begin
          grain_cnt <= '0;
          state     <= ST_REQ;
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ERR:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  ddma_flit_serializer #(
    .WORD_WIDTH (MEMORY_BUS_WIDTH),
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (state == ST_WAITD),
    .load_word (mem_data_i),
    .ready     (flit_ready_i),
    .flit      (ser_flit),
    .valid     (ser_valid),
    .last      (ser_last)
  );

  // Outputs decode registers only, so they hold steady through a stall.
  // NOTE: every signal written in always_comb gets a default first, which
  // keeps unlisted states from inferring latches.
  always_comb begin
    flit_o       = '0;
    flit_valid_o = 1'b0;
    unique case (state)
      ST_HDR:  begin flit_o = HDR_FLIT; flit_valid_o = 1'b1;      end
      ST_SIZE: begin flit_o = p_flits;  flit_valid_o = 1'b1;      end
      ST_SEND: begin flit_o = ser_flit; flit_valid_o = ser_valid; end
      default: ;
    endcase
  end

  assign mem_req_o  = state inside {ST_REQ, ST_RD, ST_WAITD, ST_SEND};
  assign mem_rd_o   = (state == ST_RD);
  assign mem_addr_o = mem_rd_o ? addr_cnt : '0;

  always_comb begin
    status_out                 = '0;
    status_out[STATUS_BUSY]    = (state != ST_IDLE);
    status_out[STATUS_DONE]    = done_flag;
    status_out[STATUS_ERR]     = err_flag;
    status_out[STATUS_OVERRUN] = overrun_flag;
    irq_out                    = '0;
    irq_out[IRQ_DONE]          = done_irq;
    irq_out[IRQ_ERR]           = err_irq;
  end

endmodule

// File: tb/tb_ddma_engine.sv
// tb_ddma_engine: self-checking bench for ddma_engine. A memory responder
// returns an address-derived word one cycle after each read; a monitor logs
// every transferred flit and read address and checks flit stability under
// backpressure. Expected packets come from a packet-level model.
module tb_ddma_engine;

  localparam int MBW     = 32;
  localparam int FW      = 16;
  localparam int AW      = MBW - 2;
  localparam int GRAIN   = 4;
  localparam int ADDRESS = 0;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  addr_in = '0;
  logic [AW-1:0]  nbytes_in = '0;
  logic           cmd_in = 1'b0;
  logic [4:0]     status_out, irq_out;
  logic           mem_req_o, mem_rd_o;
  logic           mem_gnt_i = 1'b1;
  logic [AW-1:0]  mem_addr_o;
  logic [MBW-1:0] mem_data_i;
  logic [FW-1:0]  flit_o;
  logic           flit_valid_o;
  logic           flit_ready_i = 1'b1;

  ddma_engine #(
    .MEMORY_BUS_WIDTH   (MBW),
    .FLIT_WIDTH         (FW),
    .INTERLEAVING_GRAIN (GRAIN),
    .ADDRESS            (ADDRESS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .addr_in      (addr_in),
    .nbytes_in    (nbytes_in),
    .cmd_in       (cmd_in),
    .status_out   (status_out),
    .irq_out      (irq_out),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .mem_data_i   (mem_data_i),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .flit_ready_i (flit_ready_i)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: 1-0-0-1 pattern
  int gnt_mode = 0;    // 0: always granted, 1: random
  int phase = 0;
  bit mon_en = 1'b0;

  logic [FW-1:0] got_flits[$];
  logic [AW-1:0] got_addrs[$];
  bit            req_log[$];
  bit            rd_log[$];
  logic [FW-1:0] exp_flits[$];
  logic [AW-1:0] exp_addrs[$];
  bit            prev_stall = 1'b0;
  logic [FW-1:0] prev_flit = '0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] nbytes;
    int            ready_mode;
    int            gnt_mode;
    logic [4:0]    exp_status;
    logic [4:0]    exp_irq;
    int            exp_yields;  // -1: not checked
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [MBW-1:0] mem_word(input logic [AW-1:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: data for the address read on one edge is presented until the next.
  always @(posedge clock) mem_data_i <= mem_rd_o ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (prev_stall) begin
        check("stall_valid_held", flit_valid_o, 1);
        check("stall_flit_held", flit_o, prev_flit);
      end
      if (flit_valid_o && flit_ready_i) got_flits.push_back(flit_o);
      if (mem_rd_o) got_addrs.push_back(mem_addr_o);
      req_log.push_back(mem_req_o);
      rd_log.push_back(mem_rd_o);
    end
    prev_stall = mon_en && !reset && flit_valid_o && !flit_ready_i;
    prev_flit  = flit_o;
  end

  initial begin : drive_handshake
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       flit_ready_i = 1'b1;
        1:       flit_ready_i = 1'($urandom_range(0, 1));
        default: flit_ready_i = (phase % 4 == 0) || (phase % 4 == 3);
      endcase
      mem_gnt_i = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      phase++;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: packet contents purely from the command.
  function automatic bit model_err(input logic [AW-1:0] n);
    return (n == 0) || (n % 4 != 0) || ((int'(n) / (FW / 8)) > ((1 << FW) - 1));
  endfunction

  task automatic build_expected(input logic [AW-1:0] a, input logic [AW-1:0] n);
    exp_flits.delete();
    exp_addrs.delete();
    if (!model_err(n)) begin
      int words = int'(n) / (MBW / 8);
      exp_flits.push_back(FW'(ADDRESS));
      exp_flits.push_back(FW'(int'(n) / (FW / 8)));
      for (int w = 0; w < words; w++) begin
        logic [AW-1:0]  wa = a + AW'(w);
        logic [MBW-1:0] d  = mem_word(wa);
        exp_addrs.push_back(wa);
        for (int s = 0; s < MBW / FW; s++) exp_flits.push_back(d[s*FW +: FW]);
      end
    end
  endtask

  task automatic clear_logs();
    got_flits.delete();
    got_addrs.delete();
    req_log.delete();
    rd_log.delete();
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input logic [AW-1:0] n);
    step();
    addr_in   = a;
    nbytes_in = n;
    cmd_in    = 1'b1;
    step();
    cmd_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (status_out[0] && n < budget) begin
      step();
      n++;
    end
    check({tag, "_idle"}, status_out[0], 0);
  endtask

  task automatic compare_run(input string tag, input logic [4:0] est, input logic [4:0] eirq,
                             input int eyields);
    check({tag, "_flit_count"}, got_flits.size(), exp_flits.size());
    for (int i = 0; i < exp_flits.size() && i < got_flits.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), got_flits[i], exp_flits[i]);
    check({tag, "_read_count"}, got_addrs.size(), exp_addrs.size());
    for (int i = 0; i < exp_addrs.size() && i < got_addrs.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), got_addrs[i], exp_addrs[i]);
    check({tag, "_status"}, status_out, est);
    check({tag, "_irq"}, irq_out, eirq);
    if (eyields >= 0) begin
      int first = -1;
      int last  = -1;
      int lows  = 0;
      int runs  = 0;
      foreach (rd_log[i]) if (rd_log[i]) begin
        if (first < 0) first = i;
        last = i;
      end
      for (int i = first + 1; i < last; i++) if (!req_log[i]) begin
        lows++;
        if (req_log[i-1]) runs++;
      end
      check({tag, "_req_low_cycles"}, lows, eyields);
      check({tag, "_req_low_runs"}, runs, eyields);
    end
  endtask

  task automatic run_xfer(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] n,
                          input int rmode, input int gmode, input logic [4:0] est,
                          input logic [4:0] eirq, input int eyields);
    ready_mode = rmode;
    gnt_mode   = gmode;
    clear_logs();
    mon_en = 1'b1;
    build_expected(a, n);
    start_cmd(a, n);
    wait_idle(tag, 5000);
    compare_run(tag, est, eirq, eyields);
  endtask

  initial begin : main
    vecs[0] = '{30'h10,         30'd8,       0, 0, 5'b00010, 5'b00001,  0};
    vecs[1] = '{30'h20,         30'd6,       0, 0, 5'b00100, 5'b00010, -1};
    vecs[2] = '{30'h30,         30'd0,       0, 0, 5'b00100, 5'b00010, -1};
    vecs[3] = '{30'h40,         30'd40,      0, 0, 5'b00010, 5'b00001,  2};
    vecs[4] = '{30'h3FFF_FFFE,  30'd16,      0, 0, 5'b00010, 5'b00001,  0};
    vecs[5] = '{30'h50,         30'd12,      2, 0, 5'b00010, 5'b00001,  0};
    vecs[6] = '{30'h60,         30'h2_0000,  0, 0, 5'b00100, 5'b00010, -1};
    vecs[7] = '{30'h70,         30'd4,       1, 1, 5'b00010, 5'b00001, -1};
    vecs[8] = '{30'h80,         30'd24,      0, 1, 5'b00010, 5'b00001, -1};

    // Reset state.
    repeat (3) step();
    check("rst_status", status_out, 0);
    check("rst_irq", irq_out, 0);
    check("rst_flit_valid", flit_valid_o, 0);
    check("rst_flit", flit_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_rd", mem_rd_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);

    // Reset wins over a simultaneous command.
    addr_in   = 30'h10;
    nbytes_in = 30'd8;
    cmd_in    = 1'b1;
    step();
    check("rst_over_cmd_busy", status_out[0], 0);
    cmd_in = 1'b0;
    reset  = 1'b0;

    foreach (vecs[i])
      run_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].nbytes, vecs[i].ready_mode,
               vecs[i].gnt_mode, vecs[i].exp_status, vecs[i].exp_irq, vecs[i].exp_yields);

    // Error path timing: ERR for one cycle, then idle.
    ready_mode = 0;
    gnt_mode   = 0;
    clear_logs();
    start_cmd(30'h90, 30'd2);
    check("err_cycle_status", status_out, 5'b00101);
    step();
    check("err_idle_status", status_out, 5'b00100);
    check("err_idle_irq", irq_out, 5'b00010);
    check("err_no_flits", got_flits.size(), 0);
    check("err_no_reads", got_addrs.size(), 0);

    // Command during SEND is ignored and flagged; next command clears the flag.
    clear_logs();
    build_expected(30'hA0, 30'd16);
    start_cmd(30'hA0, 30'd16);
    repeat (5) step();
    check("ovr_in_send_valid", flit_valid_o, 1);
    addr_in   = 30'h123;
    nbytes_in = 30'd8;
    cmd_in    = 1'b1;
    step();
    cmd_in = 1'b0;
    check("ovr_flag", status_out[3], 1);
    wait_idle("ovr", 5000);
    compare_run("ovr", 5'b01010, 5'b00001, 0);
    run_xfer("after_ovr", 30'hB0, 30'd4, 0, 0, 5'b00010, 5'b00001, 0);

    // Reset mid-SEND aborts without irq, then a fresh transfer works.
    clear_logs();
    start_cmd(30'hC0, 30'd40);
    repeat (5) step();
    check("rst_mid_valid_before", flit_valid_o, 1);
    reset = 1'b1;
    step();
    check("rst_mid_status", status_out, 0);
    check("rst_mid_irq", irq_out, 0);
    check("rst_mid_flit_valid", flit_valid_o, 0);
    check("rst_mid_flit", flit_o, 0);
    check("rst_mid_mem_req", mem_req_o, 0);
    check("rst_mid_mem_rd", mem_rd_o, 0);
    reset = 1'b0;
    clear_logs();
    repeat (4) step();
    check("rst_mid_no_flits", got_flits.size(), 0);
    check("rst_mid_still_idle", status_out, 0);
    run_xfer("after_rst", 30'hD0, 30'd16, 0, 0, 5'b00010, 5'b00001, 0);

    // Randomised commands, ready and grant against the packet model.
    for (int k = 0; k < 25; k++) begin
      logic [AW-1:0] a;
      logic [AW-1:0] n;
      bit            e;
      a = AW'($urandom);
      case ($urandom_range(0, 7))
        0, 1:    n = AW'($urandom_range(0, 70));
        2:       n = (AW'($urandom) | AW'(32'h2_0000)) & ~AW'(3);
        default: n = AW'(4 * $urandom_range(1, 16));
      endcase
      e = model_err(n);
      run_xfer($sformatf("rnd%0d", k), a, n, 1, 1, e ? 5'b00100 : 5'b00010,
               e ? 5'b00010 : 5'b00001, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
